// File: rtl/key_pkg.sv
// Shared types and key encodings for the key event decoder.
// Key constants match the stopwatch one-hot state encoding.
package key_pkg;

  typedef enum logic [1:0] {
    WAIT_PRESS   = 2'd0,
    WAIT_RELEASE = 2'd1,
    HOLDOFF      = 2'd2
  } key_dec_state_t;

  localparam logic [2:0] KEY_RUN   = 3'b001;
  localparam logic [2:0] KEY_CLEAR = 3'b010;
  localparam logic [2:0] KEY_IDLE  = 3'b100;

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through event FIFO; head shows the oldest entry.
// A push while full is accepted only alongside a pop.
module key_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Turns each debounced key press into one queued one-hot event.
// Optional auto-repeat: define KEY_DECODER_REPEAT_EN.
module key_event_decoder #(
  parameter int KEYS          = 3,
  parameter int DEPTH         = 4,
  parameter int HOLDOFF       = 5,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEYS-1:0]            code,
  input  logic                       strobe,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [KEYS-1:0]            evt_key,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       error
);

  import key_pkg::*;

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  key_dec_state_t  state;
  logic [HW-1:0]   hold_cnt;
  logic            code_any;
  logic            code_ok;
  logic            accept;
  logic            press_push;
  logic            rep_push;
  logic            push;
  logic            pop;
  logic            full;
  logic [KEYS-1:0] push_data;
  logic [KEYS-1:0] head;

  assign code_any   = |code;
  assign code_ok    = $onehot(code);
  assign accept     = (state == WAIT_PRESS) && strobe && code_any;
  assign press_push = accept && code_ok;
  assign push       = press_push || rep_push;
  assign pop        = evt_valid && evt_ready;
  assign evt_valid  = (count != '0);
  assign evt_key    = evt_valid ? head : '0;

  // Press / release / hold-off sequencing; hold-off restarts on bounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_PRESS;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        WAIT_PRESS: begin
          if (strobe && code_any)
            state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!strobe) begin
            if (HOLDOFF == 0) begin
              state <= WAIT_PRESS;
            end else begin
              state    <= key_pkg::HOLDOFF;
              hold_cnt <= HW'(HOLDOFF - 1);
            end
          end
        end
        key_pkg::HOLDOFF: begin
          if (strobe)
            state <= WAIT_RELEASE;
          else if (hold_cnt == '0)
            state <= WAIT_PRESS;
          else
            hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= WAIT_PRESS;
      endcase
    end
  end

`ifdef KEY_DECODER_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic            rep_ok;
  logic            rep_phase;
  logic [RW-1:0]   rep_cnt;
  logic [KEYS-1:0] rep_key;
  logic            rep_run;

  assign rep_run  = (state == WAIT_RELEASE) && strobe && rep_ok;
  assign rep_push = rep_run &&
                    (rep_phase ? (rep_cnt == RW'(REPEAT_PERIOD - 1))
                               : (rep_cnt == RW'(REPEAT_DELAY - 1)));
  assign push_data = press_push ? code : rep_key;

  // Hold timer: first repeat after the delay, then every period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_ok    <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
      rep_key   <= '0;
    end else if (accept) begin
      rep_ok    <= code_ok;
      rep_key   <= code;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_run) begin
      if (rep_push) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end else begin
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end
  end
`else
  assign rep_push  = 1'b0;
  assign push_data = code;
`endif

  // Sticky fault flags; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (push && full && !pop)
        overflow <= 1'b1;
      if (accept && !code_ok)
        error <= 1'b1;
    end
  end

  key_fifo #(
    .WIDTH (KEYS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder (default build).
// Scoreboard queue models the event FIFO contents.
module tb_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code;
  logic       strobe;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic [2:0] count;
  logic       overflow;
  logic       error;

  always #5 clk = ~clk;

  key_event_decoder #(
    .KEYS    (3),
    .DEPTH   (4),
    .HOLDOFF (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .strobe    (strobe),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .count     (count),
    .overflow  (overflow),
    .error     (error)
  );

  typedef struct {
    logic [2:0] code;
    int         exp_count;
    bit         exp_ovf;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] sb[$];
  bit         mdl_ovf = 1'b0;
  bit         mdl_err = 1'b0;
  vec_t       vecs[5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [2:0] c);
    if ($onehot(c)) begin
      if (sb.size() < 4)
        sb.push_back(c);
      else
        mdl_ovf = 1'b1;
    end else if (c != 3'b000) begin
      mdl_err = 1'b1;
    end
  endtask

  task automatic press(input logic [2:0] c, input int nh);
    code   = c;
    strobe = 1'b1;
    model_push(c);
    repeat (nh) @(negedge clk);
    strobe = 1'b0;
    code   = 3'b000;
    repeat (7) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    check({name, "_count"}, 32'(count), 32'(sb.size()));
    check({name, "_ovf"}, 32'(overflow), 32'(mdl_ovf));
    check({name, "_err"}, 32'(error), 32'(mdl_err));
  endtask

  task automatic pop_check(input string name);
    logic [2:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got key %0h", name, evt_key);
    end else begin
      exp = sb.pop_front();
      check({name, "_valid"}, 32'(evt_valid), 32'd1);
      check({name, "_key"}, 32'(evt_key), 32'(exp));
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    strobe    = 1'b1;
    code      = 3'b001;
    evt_ready = 1'b0;

    vecs[0] = '{3'b001, 1, 1'b0};
    vecs[1] = '{3'b010, 2, 1'b0};
    vecs[2] = '{3'b100, 3, 1'b0};
    vecs[3] = '{3'b001, 4, 1'b0};
    vecs[4] = '{3'b010, 4, 1'b1};

    // reset held with a key pressed
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_key", 32'(evt_key), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    rst = 1'b0;
    model_push(3'b001);
    @(negedge clk);
    check("rst_evt_valid", 32'(evt_valid), 32'd1);
    check("rst_evt_key", 32'(evt_key), 32'h1);
    check("rst_evt_count", 32'(count), 32'd1);
    strobe = 1'b0;
    code   = 3'b000;
    repeat (7) @(negedge clk);
    pop_check("rst_pop");
    check_state("rst_drain");

    // reset mid-operation discards queued events
    press(3'b010, 3);
    check_state("mid_pre");
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single long press
    code   = 3'b001;
    strobe = 1'b1;
    model_push(3'b001);
    @(negedge clk);
    check("single_valid", 32'(evt_valid), 32'd1);
    check("single_key", 32'(evt_key), 32'h1);
    check("single_count", 32'(count), 32'd1);
    repeat (9) @(negedge clk);
    strobe = 1'b0;
    code   = 3'b000;
    repeat (7) @(negedge clk);
    check_state("single_after");
    pop_check("single_pop");

    // bounce during hold-off
    code   = 3'b010;
    strobe = 1'b1;
    model_push(3'b010);
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(negedge clk);
    strobe = 1'b1;
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    code   = 3'b000;
    repeat (6) @(negedge clk);
    check_state("bounce");
    press(3'b100, 3);
    check_state("bounce_next");
    pop_check("bounce_pop0");
    pop_check("bounce_pop1");

    // full FIFO with simultaneous push and pop
    press(3'b001, 3);
    press(3'b010, 3);
    press(3'b100, 3);
    press(3'b001, 3);
    check_state("full");
    code      = 3'b100;
    strobe    = 1'b1;
    evt_ready = 1'b1;
    check("simul_head", 32'(evt_key), 32'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(3'b100);
    @(negedge clk);
    evt_ready = 1'b0;
    check_state("simul");
    repeat (2) @(negedge clk);
    strobe = 1'b0;
    code   = 3'b000;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 4; i++)
      pop_check($sformatf("simul_pop%0d", i));

    // table: fill past capacity with no consumer
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].code, 3);
      check($sformatf("tbl%0d_count", i),
            32'(count), 32'(vecs[i].exp_count));
      check($sformatf("tbl%0d_ovf", i),
            32'(overflow), 32'(vecs[i].exp_ovf));
      check_state($sformatf("tbl%0d_mdl", i));
    end
    check("ovf_head", 32'(evt_key), 32'h1);
    for (int i = 0; i < 4; i++)
      pop_check($sformatf("ovf_pop%0d", i));
    check_state("ovf_drain");

    // malformed code then a clean press
    press(3'b011, 3);
    check_state("bad");
    check("bad_err", 32'(error), 32'd1);
    press(3'b100, 3);
    check_state("bad_next");
    pop_check("bad_pop");
    check_state("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
